// File: rtl/div64x32_iter.sv
// Iterative unsigned 64-by-32 restoring divider, one quotient bit per cycle,
// with a start/busy handshake and divide-by-zero / overflow classification.
module div64x32_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        div_by_zero,
  output logic        overflow
);

  typedef enum logic [1:0] {IDLE, CHECK, DIVIDE} state_t;

  state_t      state;
  logic [63:0] d;
  logic [31:0] v;
  logic [32:0] r;
  logic [31:0] q;
  logic [4:0]  cnt;

  logic [32:0] t;
  logic [32:0] diff;
  logic        take;
  logic [32:0] r_step;
  logic [31:0] q_step;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  always_comb begin
    t      = {r[31:0], q[31]};
    diff   = t - {1'b0, v};
    take   = (t >= {1'b0, v});
    r_step = take ? diff : t;
    q_step = {q[30:0], take};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      d           <= '0;
      v           <= '0;
      r           <= '0;
      q           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            d     <= dividend;
            v     <= divisor;
            busy  <= 1'b1;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (v == 32'd0) begin
            quotient    <= 32'hFFFF_FFFF;
            remainder   <= d[31:0];
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (d[63:32] >= v) begin
            // Quotient would need more than 32 bits.
            quotient    <= 32'hFFFF_FFFF;
            remainder   <= 32'h0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            r     <= {1'b0, d[63:32]};
            q     <= d[31:0];
            cnt   <= 5'd31;
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          r   <= r_step;
          q   <= q_step;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) begin
            quotient    <= q_step;
            remainder   <= r_step[31:0];
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
